// File: rtl/echo_pkg.sv
// Shared op codes, command bytes and state encodings for the echo sounder host controller.
package echo_pkg;

    typedef enum logic [1:0] {
        OP_SET_ANGLE = 2'd0,
        OP_SET_MODE  = 2'd1,
        OP_MEASURE   = 2'd2,
        OP_SWEEP     = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_WAIT,
        ST_TX_STROBE,
        ST_TX_BUSY,
        ST_RESP_WAIT
    } host_state_e;

    typedef enum logic {
        ST_EXP_DIST,
        ST_EXP_ANGLE
    } rx_state_e;

    localparam logic [7:0] CMD_SET_ANGLE = 8'h00;
    localparam logic [7:0] CMD_SET_MODE  = 8'h04;
    localparam logic [7:0] CMD_MEASURE   = 8'h08;
    localparam int         TAG_BIT       = 0;

    function automatic logic [7:0] clear_tag(input logic [7:0] b);
        logic [7:0] r;
        r          = b;
        r[TAG_BIT] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/echo_frame_rx.sv
// Receive side: byte handshake with the UART and pairing of tagged distance/angle bytes.
// EXP_DIST waits for a distance byte | EXP_ANGLE holds a distance, waits for its angle.
module echo_frame_rx
    import echo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_oen,
    output logic       smp_valid,
    output logic [7:0] smp_distance,
    output logic [7:0] smp_angle,
    output logic       err
);

    rx_state_e  state_q, state_d;
    logic       wait_low_q, wait_low_d;
    logic       oen_q, oen_d;
    logic [7:0] dist_q, dist_d;
    logic [7:0] smp_dist_q, smp_dist_d;
    logic [7:0] smp_ang_q, smp_ang_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       take;

    always_comb begin
        take       = rx_rdy && !wait_low_q;
        state_d    = state_q;
        dist_d     = dist_q;
        smp_dist_d = smp_dist_q;
        smp_ang_d  = smp_ang_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        oen_d      = !take;
        // a held byte is consumed once; rx_rdy must drop before the next one counts
        wait_low_d = take || (wait_low_q && rx_rdy);
        if (take) begin
            case (state_q)
                ST_EXP_DIST: begin
                    if (rx_data[TAG_BIT]) begin
                        err_d = 1'b1;
                    end else begin
                        dist_d  = rx_data;
                        state_d = ST_EXP_ANGLE;
                    end
                end
                ST_EXP_ANGLE: begin
                    if (!rx_data[TAG_BIT]) begin
                        err_d  = 1'b1;
                        dist_d = rx_data;
                    end else begin
                        smp_dist_d = clear_tag(dist_q);
                        smp_ang_d  = clear_tag(rx_data);
                        valid_d    = 1'b1;
                        state_d    = ST_EXP_DIST;
                    end
                end
                default: state_d = ST_EXP_DIST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EXP_DIST;
            wait_low_q <= 1'b0;
            oen_q      <= 1'b1;
            dist_q     <= 8'h00;
            smp_dist_q <= 8'h00;
            smp_ang_q  <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_low_q <= wait_low_d;
            oen_q      <= oen_d;
            dist_q     <= dist_d;
            smp_dist_q <= smp_dist_d;
            smp_ang_q  <= smp_ang_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign rx_oen       = oen_q | rst;
    assign smp_valid    = valid_q;
    assign smp_distance = smp_dist_q;
    assign smp_angle    = smp_ang_q;
    assign err          = err_q;

endmodule

// File: rtl/echo_host_ctrl.sv
// Host request FSM: IDLE accepts a request | TX_WAIT/TX_STROBE/TX_BUSY run the UART byte
// handshake | RESP_WAIT awaits a sample pair or the timeout.
module echo_host_ctrl
    import echo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [7:0] req_arg,
    output logic       req_ready,
    input  logic       tx_rdy,
    output logic       tx_wen,
    output logic [7:0] tx_data,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_oen,
    output logic       smp_valid,
    output logic [7:0] smp_distance,
    output logic [7:0] smp_angle,
    output logic       err,
    output logic       timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
    localparam cnt_t CNT_MAX  = cnt_t'(TIMEOUT_CYCLES);

    host_state_e state_q, state_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        two_q, two_d;
    logic        resp_q, resp_d;
    logic        idx_q, idx_d;
    logic        err_q, err_d;
    logic        to_q, to_d;
    cnt_t        cnt_q, cnt_d;
    logic        rx_smp_valid;
    logic        rx_err;

    always_comb begin
        state_d   = state_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        tx_data_d = tx_data_q;
        two_d     = two_q;
        resp_d    = resp_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        to_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d   = 1'b0;
                    two_d   = 1'b0;
                    resp_d  = 1'b0;
                    state_d = ST_TX_WAIT;
                    case (op_e'(req_op))
                        OP_SET_ANGLE: begin
                            byte0_d = CMD_SET_ANGLE;
                            byte1_d = req_arg;
                            two_d   = 1'b1;
                        end
                        OP_SET_MODE: byte0_d = CMD_SET_MODE | {7'b0, req_arg[0]};
                        OP_MEASURE: begin
                            byte0_d = CMD_MEASURE;
                            resp_d  = 1'b1;
                        end
                        default: begin
                            // a sweep with an empty end sector is rejected without sending
                            if (req_arg[7:4] == 4'h0) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                byte0_d = req_arg;
                                resp_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_TX_WAIT: begin
                if (tx_rdy) begin
                    tx_data_d = idx_q ? byte1_q : byte0_q;
                    state_d   = ST_TX_STROBE;
                end
            end
            ST_TX_STROBE: state_d = ST_TX_BUSY;
            ST_TX_BUSY: begin
                if (!tx_rdy) begin
                    if (two_q && !idx_q) begin
                        idx_d   = 1'b1;
                        state_d = ST_TX_WAIT;
                    end else if (resp_q) begin
                        cnt_d   = '0;
                        state_d = ST_RESP_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP_WAIT: begin
                if (rx_smp_valid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            byte0_q   <= 8'h00;
            byte1_q   <= 8'h00;
            tx_data_q <= 8'h00;
            two_q     <= 1'b0;
            resp_q    <= 1'b0;
            idx_q     <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            byte0_q   <= byte0_d;
            byte1_q   <= byte1_d;
            tx_data_q <= tx_data_d;
            two_q     <= two_d;
            resp_q    <= resp_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
        end
    end

    echo_frame_rx u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .rx_oen       (rx_oen),
        .smp_valid    (rx_smp_valid),
        .smp_distance (smp_distance),
        .smp_angle    (smp_angle),
        .err          (rx_err)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign tx_wen    = (state_q != ST_TX_STROBE) | rst;
    assign tx_data   = tx_data_q;
    assign smp_valid = rx_smp_valid;
    assign err       = err_q | rx_err;
    assign timeout   = to_q;

endmodule

// File: tb/tb_echo_host_ctrl.sv
// Directed bench for echo_host_ctrl with UART models and TX/sample scoreboards.
module tb_echo_host_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_arg = 8'h00;
    logic       tx_rdy = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       req_ready, tx_wen, rx_oen, smp_valid, err, timeout;
    logic [7:0] tx_data, smp_distance, smp_angle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_cnt = 0, smp_cnt = 0, err_cnt = 0, to_cnt = 0;
    int strobe_cyc = 0, to_cyc = 0, busy = 0;
    int e0, s0;
    logic [7:0]  last_tx = 8'h00;
    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_smp_q[$];
    logic [7:0]  exp_b;
    logic [15:0] exp_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    echo_host_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_arg      (req_arg),
        .req_ready    (req_ready),
        .tx_rdy       (tx_rdy),
        .tx_wen       (tx_wen),
        .tx_data      (tx_data),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .rx_oen       (rx_oen),
        .smp_valid    (smp_valid),
        .smp_distance (smp_distance),
        .smp_angle    (smp_angle),
        .err          (err),
        .timeout      (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: busy for three cycles after each write strobe
    initial forever begin
        @(negedge clk);
        if (busy > 0) begin
            chk("tx_wen_single", 32'(tx_wen), 32'd1);
            chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
            busy--;
            if (busy == 0) tx_rdy = 1'b1;
        end else if (tx_wen === 1'b0) begin
            strobe_cyc = cyc;
            last_tx    = tx_data;
            tx_cnt++;
            chk("tx_expected", 32'(exp_tx_q.size() > 0), 32'd1);
            if (exp_tx_q.size() > 0) begin
                exp_b = exp_tx_q.pop_front();
                chk("tx_byte", 32'(tx_data), 32'(exp_b));
            end
            tx_rdy = 1'b0;
            busy   = 3;
        end
    end

    initial forever begin
        @(negedge clk);
        if (smp_valid === 1'b1) begin
            smp_cnt++;
            chk("smp_expected", 32'(exp_smp_q.size() > 0), 32'd1);
            if (exp_smp_q.size() > 0) begin
                exp_s = exp_smp_q.pop_front();
                chk("smp_distance", 32'(smp_distance), 32'(exp_s[15:8]));
                chk("smp_angle", 32'(smp_angle), 32'(exp_s[7:0]));
            end
        end
        if (err === 1'b1) err_cnt++;
        if (timeout === 1'b1) begin
            to_cyc = cyc;
            to_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] arg);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(n < 100), 32'd1);
        req_op    = op;
        req_arg   = arg;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        while (rx_oen !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rx_oen_strobe", 32'(n < 20), 32'd1);
        rx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_count", tx_cnt, target);
    endtask

    task automatic wait_smp(input int target);
        int n = 0;
        while (smp_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("smp_count", smp_cnt, target);
    endtask

    task automatic wait_to(input int target);
        int n = 0;
        while (to_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_count", to_cnt, target);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_tx_wen", 32'(tx_wen), 32'd1);
        chk("rst_rx_oen", 32'(rx_oen), 32'd1);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_smp_valid", 32'(smp_valid), 32'd0);
        chk("rst_smp_distance", 32'(smp_distance), 32'h00);
        chk("rst_smp_angle", 32'(smp_angle), 32'h00);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // MEASURE with a response pair
        exp_tx_q.push_back(8'h08);
        do_req(2'd2, 8'h00);
        wait_tx(1);
        idle(5);
        chk("measure_resp_wait", 32'(req_ready), 32'd0);
        exp_smp_q.push_back({8'h64, 8'h80});
        send_rx(8'h64);
        send_rx(8'h81);
        wait_smp(1);
        @(negedge clk);
        chk("measure_idle_after_smp", 32'(req_ready), 32'd1);
        idle(20);
        chk("measure_no_timeout", to_cnt, 0);
        chk("measure_no_err", err_cnt, 0);

        // SET_ANGLE: two bytes, a request during the transfer is dropped
        exp_tx_q.push_back(8'h00);
        exp_tx_q.push_back(8'h40);
        do_req(2'd0, 8'h40);
        chk("busy_not_ready", 32'(req_ready), 32'd0);
        req_op    = 2'd2;
        req_valid = 1'b1;
        idle(3);
        req_valid = 1'b0;
        wait_tx(3);
        idle(25);
        chk("set_angle_no_extra_tx", tx_cnt, 3);
        chk("set_angle_no_resp_wait", to_cnt, 0);
        chk("set_angle_idle", 32'(req_ready), 32'd1);

        // SET_MODE carries mode bit0 only
        exp_tx_q.push_back(8'h05);
        do_req(2'd1, 8'h03);
        wait_tx(4);
        idle(6);
        chk("set_mode_idle", 32'(req_ready), 32'd1);

        // SWEEP with empty end sector is rejected
        e0 = err_cnt;
        do_req(2'd3, 8'h05);
        idle(3);
        chk("sweep_bad_err", err_cnt, e0 + 1);
        chk("sweep_bad_no_tx", tx_cnt, 4);
        chk("sweep_bad_ready", 32'(req_ready), 32'd1);

        // legal SWEEP, no response so it times out
        exp_tx_q.push_back(8'hA2);
        do_req(2'd3, 8'hA2);
        wait_tx(5);
        wait_to(1);

        // timeout position: RESP_WAIT entered two cycles after the strobe
        exp_tx_q.push_back(8'h08);
        do_req(2'd2, 8'h00);
        wait_tx(6);
        wait_to(2);
        chk("timeout_latency", to_cyc - strobe_cyc, 18);
        @(negedge clk);
        chk("timeout_pulse_single", 32'(timeout), 32'd0);
        chk("timeout_ready", 32'(req_ready), 32'd1);

        // tag errors and resync on an unsolicited stream
        e0 = err_cnt;
        s0 = smp_cnt;
        exp_smp_q.push_back({8'h20, 8'h40});
        send_rx(8'h81);
        send_rx(8'h10);
        send_rx(8'h20);
        send_rx(8'h41);
        idle(3);
        chk("resync_err_count", err_cnt, e0 + 2);
        chk("resync_smp_count", smp_cnt, s0 + 1);
        chk("resync_queue_empty", exp_smp_q.size(), 0);

        // reset drops a held distance byte
        s0 = smp_cnt;
        send_rx(8'h32);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_tx_wen", 32'(tx_wen), 32'd1);
        chk("rst_cycle_rx_oen", 32'(rx_oen), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_smp_distance", 32'(smp_distance), 32'h00);
        chk("rst2_smp_angle", 32'(smp_angle), 32'h00);
        chk("rst2_tx_data", 32'(tx_data), 32'h00);
        chk("rst2_req_ready", 32'(req_ready), 32'd1);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_timeout", 32'(timeout), 32'd0);
        e0 = err_cnt;
        send_rx(8'h11);
        idle(3);
        chk("rst2_no_sample", smp_cnt, s0);
        chk("rst2_angle_err", err_cnt, e0 + 1);
        chk("tx_queue_drained", exp_tx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
